// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file bank.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep sequencer: walks every entry once, zeroing one per cycle.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;

  // Sweep FSM; terminal count is compared explicitly so the counter never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_cnt   <= {ADDR_W{1'b0}};
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_clear) begin
            r_state <= CLEAR;
            r_cnt   <= {ADDR_W{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        CLEAR: begin
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = r_busy;
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/regfile_bank.sv
// Two-read / one-write register file with byte enables, write-through bypass
// and a cycle-per-entry clear sweep in place of a storage reset.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   ReadAddr1,
  input  logic [ADDR_W-1:0]   ReadAddr2,
  input  logic [ADDR_W-1:0]   WriteAddr,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] ByteEn,
  input  logic                RegWrite,
  input  logic                Clear,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic                Busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_en;
  logic              w_wr_zero;
  logic [DATA_W-1:0] w_merged;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] new_d,
    input logic [DATA_W-1:0] old_d,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_d;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_d[8*i +: 8];
    end
    return res;
  endfunction

  // Forced zero while sweeping/resetting or for the hardwired entry; bypass on address match.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] merged,
    input logic              blank,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wa
  );
    logic [DATA_W-1:0] res;
    if (blank || (ZERO_REG && (ra == {ADDR_W{1'b0}}))) begin
      res = {DATA_W{1'b0}};
    end else if (wr_en && (ra == wa)) begin
      res = merged;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
    .i_clk      (Clock),
    .i_rst      (Reset),
    .i_clear    (Clear),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_wr_zero = ZERO_REG && (WriteAddr == {ADDR_W{1'b0}});
  assign w_wr_en   = RegWrite && !w_busy && !Reset && !w_wr_zero;
  assign w_merged  = byte_merge(WriteData, r_mem[WriteAddr], ByteEn);

  // Storage update: the sweep owns the array while busy; no reset term on the array.
  always_ff @(posedge Clock) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= {DATA_W{1'b0}};
    end else if (w_wr_en) begin
      r_mem[WriteAddr] <= w_merged;
    end
  end

  // Combinational read ports.
  always_comb begin
    ReadData1 = {DATA_W{1'b0}};
    ReadData2 = {DATA_W{1'b0}};
    ReadData1 = read_port(ReadAddr1, r_mem[ReadAddr1], w_merged,
                          w_busy || Reset, w_wr_en, WriteAddr);
    ReadData2 = read_port(ReadAddr2, r_mem[ReadAddr2], w_merged,
                          w_busy || Reset, w_wr_en, WriteAddr);
  end

  assign Busy = w_busy;

endmodule

// File: doc/regfile_bank.md
REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter DATA_W, default 32, shall set the register width in bits and shall be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, shall set the address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, shall hardwire entry 0 to zero when 1.
REQ-004 Port Clock, input, 1: the single clock; all state shall update on its rising edge.
REQ-005 Port Reset, input, 1: synchronous, active-high reset.
REQ-006 Port ReadAddr1 / ReadAddr2, input, ADDR_W each: read port addresses.
REQ-007 Port WriteAddr, input, ADDR_W: write address.
REQ-008 Port WriteData, input, DATA_W: write data.
REQ-009 Port ByteEn, input, DATA_W/8: per-byte write enable, with bit i covering bits 8i+7..8i.
REQ-010 Port RegWrite, input, 1: active-high write strobe.
REQ-011 Port Clear, input, 1: single-cycle request to start a clear sweep without Reset.
REQ-012 Port ReadData1 / ReadData2, output, DATA_W each: read data.
REQ-013 Port Busy, output, 1: high while a clear sweep is in progress.

Function
REQ-014 The write shall be synchronous: on the rising edge, when RegWrite=1 and Busy=0, each byte with ByteEn[i]=1 shall be written; other bytes shall be kept.
REQ-015 With ZERO_REG=1, writes to address 0 shall be discarded and reads of address 0 shall return 0.
REQ-016 Reads shall be combinational, with zero-cycle latency from address to data.
REQ-017 Same-cycle bypass: when RegWrite=1, Busy=0 and ReadAddrN==WriteAddr (non-zero address if ZERO_REG=1), ReadDataN shall return the merged value: enabled bytes from WriteData, the rest from the stored entry.
REQ-018 The FSM shall have two states, IDLE and CLEAR.
REQ-019 In CLEAR, a ADDR_W-bit counter shall zero one entry per cycle, from 0 up to DEPTH-1.
REQ-020 The FSM shall move from CLEAR to IDLE on the cycle after the entry at counter DEPTH-1 is written.
REQ-021 A clear sweep shall last exactly DEPTH cycles.
REQ-022 In IDLE, Clear=1 shall move the FSM to CLEAR with the counter at 0 on the next edge.
REQ-023 Busy shall be 1 exactly when the state is CLEAR.
REQ-024 While Busy=1, RegWrite shall be ignored (the write is dropped, not queued) and ReadData1/2 shall return 0.
REQ-025 Clear asserted while in CLEAR shall be ignored; it shall neither restart nor extend the sweep.
REQ-026 The counter shall not wrap; the terminal count shall be detected explicitly.

Reset
REQ-027 Reset=1 on a rising edge shall force the state to CLEAR with the counter at 0, including when asserted mid-sweep (the sweep restarts at 0).
REQ-028 While Reset is held, Busy shall be 1 and ReadData1/2 shall be 0.
REQ-029 After Reset deasserts, the sweep shall complete DEPTH cycles later.
REQ-030 Reset shall take priority over Clear and RegWrite.
REQ-031 The storage array itself shall have no reset term; zeroing shall come only from the sweep.

Structure
REQ-032 Package regfile_pkg shall hold the state enumeration (IDLE, CLEAR) and the default DATA_W / ADDR_W constants.
REQ-033 Sub-module regfile_clear_ctrl shall contain the FSM, counter and Busy, and shall output the clear-write enable and clear address.
REQ-034 The top level shall hold the storage array, the byte merge, the bypass and the read muxes.

Verification
REQ-035 Reset for 1 cycle, then idle -> Busy=1 for exactly 32 cycles after deassertion; afterwards ReadData1 at addresses 0..31 = 0x00000000.
REQ-036 Write 0xDEADBEEF to r5 with ByteEn=4'b1111, then write 0x000000AA to r5 with ByteEn=4'b0001 -> reading r5 returns 0xDEADBEAA.
REQ-037 Same cycle: RegWrite=1, WriteAddr=7, WriteData=0x12345678, ByteEn=4'b1111, ReadAddr1=7 -> ReadData1=0x12345678 in that cycle, and r7 holds it on later cycles.
REQ-038 Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> reading r0 returns 0; with ReadAddr2=0 during the write, ReadData2=0.
REQ-039 Clear pulse after filling r1..r31, then Reset asserted on sweep cycle 10 -> sweep restarts at 0; Busy stays high for 32 cycles after Reset deasserts; all entries read 0.
REQ-040 RegWrite to r3 during Busy, and a second Clear mid-sweep -> r3 reads 0 after the sweep, and the sweep length stays 32 cycles.
